uart_xmit_arbiter: RTL and testbench
====================================

Name: uart_xmit_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter (u_xmit) among NUM_REQ byte requesters.
- Sits between requester logic and the transmitter. It latches the winning byte and pulses xmitH. It then tracks the transmitter's xmit_doneH (high when idle, low while sending) through one full frame before granting again.
- A watchdog recovers from a transmitter that never starts or never finishes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, idle cycles inserted after each completed frame before the next grant (0..15).
- TIMEOUT, 1023, max cycles allowed in WAIT_BUSY or WAIT_DONE before abort; counter width is clog2(TIMEOUT+1).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- req_vld  in  NUM_REQ  per-requester byte-valid, level; held until acked.
- req_data  in  NUM_REQ*8  requester i byte at bits [8i+7:8i].
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- xmitH  out  1  one-cycle transmit strobe to u_xmit.
- xmit_dataH  out  8  latched byte to u_xmit; stable from START until next grant.
- xmit_doneH  in  1  transmitter done/idle, high when idle.
- busy  out  1  high in every state except IDLE.
- grant_id  out  clog2(NUM_REQ)  index of last granted requester.
- timeout_err  out  1  sticky watchdog flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (sync, sys_rst=1 at clock edge): state=IDLE, req_ack=0, xmitH=0, xmit_dataH=0, busy=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), timeout_err=0, counters=0. Reset mid-frame aborts with no ack and no further xmitH.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP, ABORT. All outputs are registered.
- IDLE:
  - Advance when |req_vld and xmit_doneH=1.
  - Winner = first i with req_vld[i]=1, scanning grant_id+1, grant_id+2, ... modulo NUM_REQ.
  - Same edge: xmit_dataH<=req_data[winner], grant_id<=winner, req_ack[winner]<=1, go to START.
  - req_vld seen while xmit_doneH=0 is ignored; stay in IDLE.
- START: xmitH=1 for exactly this one cycle, req_ack cleared, timer cleared. Next state WAIT_BUSY. Latency is req_vld sampled -> ack at +1 and xmitH at +1 (same cycle).
- WAIT_BUSY:
  - xmit_doneH=0 -> WAIT_DONE, timer cleared.
  - Otherwise timer increments; timer==TIMEOUT -> ABORT.
- WAIT_DONE:
  - xmit_doneH=1 -> GAP, gap counter cleared.
  - Otherwise timer increments; timer==TIMEOUT -> ABORT.
- GAP: count GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0 returns to IDLE on the next cycle.
- ABORT: timeout_err<=1, one cycle, then IDLE. The byte is not retried; it was already acked.
- err_clr=1 clears timeout_err. If err_clr coincides with a new abort, set wins.
- Requester dropping req_vld before ack: no grant is taken. Requester dropping it after ack: no effect.
- Only one req_ack bit is ever high; xmitH is never high outside START.
- Arbiter does not observe bytes; data integrity belongs to the requester.

Test Plan:
- Single request: req_vld=4'b0001, data 8'h41, model u_xmit drops xmit_doneH 2 cycles after xmitH and raises it 160 cycles later -> req_ack[0] and xmitH pulse once, xmit_dataH=8'h41, busy for frame+GAP_CYCLES, then IDLE.
- Round-robin: all four req_vld held high with data 8'h10..8'h13 -> grant order 0,1,2,3,0; xmit_dataH sequence 10,11,12,13,10; one ack per frame.
- Transmitter never starts: xmit_doneH stuck at 1 -> ABORT after TIMEOUT+1 cycles in WAIT_BUSY, timeout_err=1 until err_clr, next request serviced normally.
- Transmitter hangs mid-frame: xmit_doneH stuck at 0 -> ABORT, timeout_err set. err_clr asserted the same cycle as a second abort -> flag stays 1.
- Reset mid-frame: sys_rst=1 during WAIT_DONE -> next cycle all outputs at reset values, grant_id=NUM_REQ-1, requester 0 wins next.
- Transmitter busy at request: xmit_doneH=0 when req_vld rises -> no ack until xmit_doneH=1, then grant on that edge.

Source files
------------

// File: rtl/uart_xmit_arbiter_if.sv
// Requester/transmitter-facing bundle of the UART transmit arbiter.
// The arbiter takes the slave side; requesters and the transmitter model take the master side.
interface uart_xmit_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_vld;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 xmitH;
  logic [7:0]           xmit_dataH;
  logic                 xmit_doneH;
  logic                 busy;
  logic [GRANT_W-1:0]   grant_id;
  logic                 timeout_err;
  logic                 err_clr;

  modport master (
    output req_vld, req_data, xmit_doneH, err_clr,
    input  req_ack, xmitH, xmit_dataH, busy, grant_id, timeout_err
  );

  modport slave (
    input  req_vld, req_data, xmit_doneH, err_clr,
    output req_ack, xmitH, xmit_dataH, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_xmit_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters,
// with a watchdog that aborts frames the transmitter never starts or never finishes.
module uart_xmit_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  uart_xmit_arbiter_if.slave bus
);
  localparam int unsigned GRANT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TIMER_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned GAP_W     = 4;
  localparam int unsigned GAP_CMP_W = GAP_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP,
    ABORT
  } arbState_t;

  arbState_t            stateQ, stateNext;
  logic [NUM_REQ-1:0]   ackQ, ackNext;
  logic                 xmitQ, xmitNext;
  logic [7:0]           dataQ, dataNext;
  logic                 busyQ;
  logic [GRANT_W-1:0]   grantQ, grantNext;
  logic [TIMER_W-1:0]   timerQ, timerNext;
  logic [GAP_W-1:0]     gapQ, gapNext;
  logic                 errQ, errNext;

  logic                 winFound;
  logic [GRANT_W-1:0]   winIdx;
  logic [GRANT_W-1:0]   scanIdx;
  logic                 timerExpired;
  logic                 gapDone;

  // Rotating-priority scan starting just after the last granted requester.
  always_comb begin
    winFound = 1'b0;
    winIdx   = grantQ;
    scanIdx  = grantQ;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      scanIdx = GRANT_W'((int'(grantQ) + k) % int'(NUM_REQ));
      if (!winFound && bus.req_vld[scanIdx]) begin
        winFound = 1'b1;
        winIdx   = scanIdx;
      end
    end
  end

  assign timerExpired = (timerQ == TIMER_W'(TIMEOUT));
  // GAP always lasts at least one cycle, even with GAP_CYCLES of zero.
  assign gapDone = (GAP_CMP_W'(gapQ) + GAP_CMP_W'(1)) >= GAP_CMP_W'(GAP_CYCLES);

  // Next-state and next-output logic; every output is a register loaded from here.
  always_comb begin
    stateNext = stateQ;
    ackNext   = '0;
    xmitNext  = 1'b0;
    dataNext  = dataQ;
    grantNext = grantQ;
    timerNext = timerQ;
    gapNext   = gapQ;
    errNext   = errQ;

    if (bus.err_clr) begin
      errNext = 1'b0;
    end

    case (stateQ)
      IDLE: begin
        if (winFound && bus.xmit_doneH) begin
          stateNext       = START;
          ackNext[winIdx] = 1'b1;
          xmitNext        = 1'b1;
          dataNext        = bus.req_data[{winIdx, 3'b000} +: 8];
          grantNext       = winIdx;
        end
      end

      START: begin
        stateNext = WAIT_BUSY;
        timerNext = '0;
      end

      WAIT_BUSY: begin
        if (!bus.xmit_doneH) begin
          stateNext = WAIT_DONE;
          timerNext = '0;
        end else if (timerExpired) begin
          stateNext = ABORT;
        end else begin
          timerNext = timerQ + TIMER_W'(1);
        end
      end

      WAIT_DONE: begin
        if (bus.xmit_doneH) begin
          stateNext = GAP;
          gapNext   = '0;
        end else if (timerExpired) begin
          stateNext = ABORT;
        end else begin
          timerNext = timerQ + TIMER_W'(1);
        end
      end

      GAP: begin
        if (gapDone) begin
          stateNext = IDLE;
        end else begin
          gapNext = gapQ + GAP_W'(1);
        end
      end

      ABORT: begin
        // A new abort overrides a simultaneous clear.
        errNext   = 1'b1;
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stateQ <= IDLE;
      ackQ   <= '0;
      xmitQ  <= 1'b0;
      dataQ  <= '0;
      busyQ  <= 1'b0;
      grantQ <= GRANT_W'(NUM_REQ - 1);
      timerQ <= '0;
      gapQ   <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateNext;
      ackQ   <= ackNext;
      xmitQ  <= xmitNext;
      dataQ  <= dataNext;
      busyQ  <= (stateNext != IDLE);
      grantQ <= grantNext;
      timerQ <= timerNext;
      gapQ   <= gapNext;
      errQ   <= errNext;
    end
  end

  assign bus.req_ack     = ackQ;
  assign bus.xmitH       = xmitQ;
  assign bus.xmit_dataH  = dataQ;
  assign bus.busy        = busyQ;
  assign bus.grant_id    = grantQ;
  assign bus.timeout_err = errQ;

  // Safety properties: at most one ack, strobe only in START, busy mirrors the state.
  assert property (@(posedge sys_clk) disable iff (sys_rst) $onehot0(ackQ));
  assert property (@(posedge sys_clk) disable iff (sys_rst) xmitQ |-> (stateQ == START));
  assert property (@(posedge sys_clk) disable iff (sys_rst) busyQ == (stateQ != IDLE));

endmodule

// File: tb/tb_uart_xmit_arbiter.sv
// Self-checking bench for uart_xmit_arbiter: arbitration vector table, scoreboard of
// expected grants, and hand-written watchdog / reset / busy-transmitter sequences.
module tb_uart_xmit_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int FRAME     = 160;
  localparam int NORM_BUSY = 165;   // START + 2 WAIT_BUSY + 160 WAIT_DONE + 2 GAP
  localparam int NOSTART_BUSY = 1026; // START + 1024 WAIT_BUSY + ABORT
  localparam int HANG_BUSY = 1028;  // START + 2 WAIT_BUSY + 1024 WAIT_DONE + ABORT

  localparam int MODE_NORMAL   = 0;
  localparam int MODE_STUCK_HI = 1;
  localparam int MODE_HANG     = 2;
  localparam int MODE_MANUAL   = 3;

  logic sys_clk;
  logic sys_rst;

  uart_xmit_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_xmit_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .GAP_CYCLES(2),
    .TIMEOUT   (1023)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int testsRun;
  int testsFailed;

  typedef struct packed {
    logic [1:0] grant;
    logic [7:0] data;
  } expItem_t;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic [1:0]  grant;
    logic [7:0]  byteExp;
  } vec_t;

  expItem_t sbQ[$];
  expItem_t monItem;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Transmitter model: done drops 2 cycles after xmitH and stays low for FRAME cycles.
  int   xmitMode;
  logic manualDone;
  logic modelDone;
  int   mSt;
  int   mCnt;

  always @(posedge sys_clk) begin
    if (sys_rst || xmitMode == MODE_MANUAL) begin
      mSt       <= 0;
      mCnt      <= 0;
      modelDone <= 1'b1;
    end else begin
      case (mSt)
        0: if (bus.xmitH && xmitMode != MODE_STUCK_HI) mSt <= 1;
        1: begin
          modelDone <= 1'b0;
          mSt       <= 2;
          mCnt      <= 1;
        end
        default: begin
          if (xmitMode != MODE_HANG) begin
            if (mCnt == FRAME) begin
              modelDone <= 1'b1;
              mSt       <= 0;
            end else begin
              mCnt <= mCnt + 1;
            end
          end
        end
      endcase
    end
  end

  assign bus.xmit_doneH = (xmitMode == MODE_MANUAL) ? manualDone : modelDone;

  // Scoreboard monitor: each strobe must match the oldest expected grant.
  always @(negedge sys_clk) begin
    if (bus.xmitH === 1'b1) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("FAIL sb_unexpected_xmit: got xmitH=1 expected no strobe");
      end else begin
        monItem = sbQ.pop_front();
        check("sb_grant", 32'(bus.grant_id), 32'(monItem.grant));
        check("sb_data", 32'(bus.xmit_dataH), 32'(monItem.data));
        check("sb_ack", 32'(bus.req_ack), 32'(4'b0001 << monItem.grant));
      end
    end
  end

  task automatic waitXmit(input string name, input int budget);
    int n;
    n = 0;
    while (bus.xmitH !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (bus.xmitH !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("FAIL %s: got no xmitH within %0d cycles expected a strobe", name, budget);
    end
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 3000) begin
      cycles++;
      tick();
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_ack"}, 32'(bus.req_ack), 32'h0);
    check({tag, "_xmitH"}, 32'(bus.xmitH), 32'h0);
    check({tag, "_data"}, 32'(bus.xmit_dataH), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_grant"}, 32'(bus.grant_id), 32'(NUM_REQ - 1));
    check({tag, "_err"}, 32'(bus.timeout_err), 32'h0);
  endtask

  // Issue one request, check the ack on the very next edge, then release it.
  task automatic request(input string name, input logic [3:0] vld, input logic [31:0] data,
                         input logic [1:0] grant, input logic [7:0] byteExp);
    sbQ.push_back('{grant: grant, data: byteExp});
    bus.req_vld  = vld;
    bus.req_data = data;
    tick();
    check({name, "_ack"}, 32'(bus.req_ack), 32'(4'b0001 << grant));
    check({name, "_xmitH"}, 32'(bus.xmitH), 32'h1);
    bus.req_vld = '0;
  endtask

  vec_t vecs[9];
  int   cyc;

  initial begin
    vecs[0] = '{vld: 4'b0001, data: 32'h44332211, grant: 2'd0, byteExp: 8'h11};
    vecs[1] = '{vld: 4'b1001, data: 32'h44332211, grant: 2'd3, byteExp: 8'h44};
    vecs[2] = '{vld: 4'b1001, data: 32'h8899AABB, grant: 2'd0, byteExp: 8'hBB};
    vecs[3] = '{vld: 4'b0110, data: 32'h8899AABB, grant: 2'd1, byteExp: 8'hAA};
    vecs[4] = '{vld: 4'b0110, data: 32'h5A6B7C8D, grant: 2'd2, byteExp: 8'h6B};
    vecs[5] = '{vld: 4'b1111, data: 32'h5A6B7C8D, grant: 2'd3, byteExp: 8'h5A};
    vecs[6] = '{vld: 4'b1100, data: 32'hF0E1D2C3, grant: 2'd2, byteExp: 8'hE1};
    vecs[7] = '{vld: 4'b0010, data: 32'hF0E1D2C3, grant: 2'd1, byteExp: 8'hD2};
    vecs[8] = '{vld: 4'b1010, data: 32'h01020304, grant: 2'd3, byteExp: 8'h01};

    testsRun     = 0;
    testsFailed  = 0;
    xmitMode     = MODE_NORMAL;
    manualDone   = 1'b1;
    sys_rst      = 1'b1;
    bus.req_vld  = '0;
    bus.req_data = '0;
    bus.err_clr  = 1'b0;
    tick();
    tick();
    checkReset("reset");
    sys_rst = 1'b0;
    tick();

    // Round-robin with every requester held high.
    sbQ.push_back('{grant: 2'd0, data: 8'h10});
    sbQ.push_back('{grant: 2'd1, data: 8'h11});
    sbQ.push_back('{grant: 2'd2, data: 8'h12});
    sbQ.push_back('{grant: 2'd3, data: 8'h13});
    sbQ.push_back('{grant: 2'd0, data: 8'h10});
    bus.req_vld  = 4'b1111;
    bus.req_data = 32'h13121110;
    for (int n = 0; n < 5; n++) begin
      waitXmit("rr_xmit", 400);
      if (n == 4) bus.req_vld = '0;
      tick();
    end
    waitIdle(cyc);
    check("rr_sb_drained", 32'(sbQ.size()), 32'h0);

    // Single request through one full frame.
    request("single", 4'b0001, 32'h00000041, 2'd0, 8'h41);
    waitIdle(cyc);
    check("single_busy_cycles", 32'(cyc), 32'(NORM_BUSY));
    check("single_data_hold", 32'(bus.xmit_dataH), 32'h41);
    check("single_err", 32'(bus.timeout_err), 32'h0);

    // Arbitration vector table.
    foreach (vecs[i]) begin
      request("vec", vecs[i].vld, vecs[i].data, vecs[i].grant, vecs[i].byteExp);
      check("vec_grant_id", 32'(bus.grant_id), 32'(vecs[i].grant));
      waitIdle(cyc);
      check("vec_busy_cycles", 32'(cyc), 32'(NORM_BUSY));
    end

    // Transmitter busy when the request rises: no grant until done returns.
    xmitMode     = MODE_MANUAL;
    manualDone   = 1'b0;
    bus.req_vld  = 4'b0100;
    bus.req_data = 32'h00AB0000;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("held_off_ack", 32'(bus.req_ack), 32'h0);
    end
    check("held_off_busy", 32'(bus.busy), 32'h0);
    sbQ.push_back('{grant: 2'd2, data: 8'hAB});
    manualDone = 1'b1;
    tick();
    check("held_off_grant", 32'(bus.req_ack), 32'h4);
    xmitMode    = MODE_NORMAL;
    bus.req_vld = '0;
    waitIdle(cyc);
    check("held_off_busy_cycles", 32'(cyc), 32'(NORM_BUSY));

    // Transmitter never starts.
    xmitMode = MODE_STUCK_HI;
    request("nostart", 4'b0010, 32'h0000CD00, 2'd1, 8'hCD);
    waitIdle(cyc);
    check("nostart_busy_cycles", 32'(cyc), 32'(NOSTART_BUSY));
    check("nostart_err", 32'(bus.timeout_err), 32'h1);
    tick();
    tick();
    check("nostart_err_sticky", 32'(bus.timeout_err), 32'h1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("err_cleared", 32'(bus.timeout_err), 32'h0);
    xmitMode = MODE_NORMAL;
    request("after_abort", 4'b0001, 32'h000000EF, 2'd0, 8'hEF);
    waitIdle(cyc);
    check("after_abort_busy_cycles", 32'(cyc), 32'(NORM_BUSY));
    check("after_abort_err", 32'(bus.timeout_err), 32'h0);

    // Transmitter hangs mid-frame.
    xmitMode = MODE_HANG;
    request("hang", 4'b1000, 32'h77000000, 2'd3, 8'h77);
    waitIdle(cyc);
    check("hang_busy_cycles", 32'(cyc), 32'(HANG_BUSY));
    check("hang_err", 32'(bus.timeout_err), 32'h1);
    xmitMode = MODE_MANUAL;
    manualDone = 1'b1;
    tick();

    // Second hang with err_clr landing in the ABORT cycle: set must win.
    xmitMode = MODE_HANG;
    request("hang2", 4'b0001, 32'h00000066, 2'd0, 8'h66);
    for (int n = 1; n < HANG_BUSY; n++) tick();
    check("hang2_in_abort_busy", 32'(bus.busy), 32'h1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("hang2_set_wins", 32'(bus.timeout_err), 32'h1);
    check("hang2_idle", 32'(bus.busy), 32'h0);
    xmitMode = MODE_MANUAL;
    tick();
    xmitMode = MODE_NORMAL;

    // Reset during WAIT_DONE, with the sticky error still set.
    request("rstmid", 4'b0100, 32'h00550000, 2'd2, 8'h55);
    for (int n = 0; n < 20; n++) tick();
    check("rstmid_busy", 32'(bus.busy), 32'h1);
    sys_rst = 1'b1;
    tick();
    checkReset("rstmid");
    sys_rst = 1'b0;
    tick();
    check("rstmid_no_strobe", 32'(bus.xmitH), 32'h0);
    request("post_rst", 4'b0101, 32'h00990088, 2'd0, 8'h88);
    waitIdle(cyc);
    check("post_rst_busy_cycles", 32'(cyc), 32'(NORM_BUSY));
    check("sb_final_drained", 32'(sbQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
